// File: rtl/rpn_stack_core.sv
// RPN calculator datapath: WIDTH-bit, DEPTH-entry operand stack with
// single-cycle stack/ALU commands and a bit-serial restoring divider.
module rpn_stack_core #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int DW = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             op_valid,
  input  logic [2:0]       op,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             ovf,
  output logic             err_full,
  output logic             err_under,
  output logic             err_div0
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2, OP_DIV = 3'd3;
  localparam logic [2:0] OP_DUP = 3'd4, OP_SWAP = 3'd5, OP_DROP = 3'd6, OP_CLEAR = 3'd7;

  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_WB} state_t;

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       mem [DEPTH];
  logic [DW-1:0]          depth_nxt, dm1, dm2;
  logic [WIDTH-1:0]       top_nxt, nos;
  logic                   ovf_nxt, err_full_nxt, err_under_nxt, err_div0_nxt, done_nxt;
  logic                   we0, we1;
  logic [AW-1:0]          wa0, wa1;
  logic [WIDTH-1:0]       wd0, wd1;
  logic                   acc_push, acc_op, div_load;
  logic [WIDTH:0]         sum, diff;
  logic [2*WIDTH-1:0]     prod, step;
  logic [WIDTH-1:0]       dvs_p1, rem_p1, quo_p1;
  logic [CW-1:0]          cnt_p1;

  // One restoring-division iteration: returns {remainder, quotient shift register}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] trial;
    logic           q_bit;
    trial = {rem, quo[WIDTH-1]};
    q_bit = (trial >= {1'b0, dvs});
    if (q_bit) trial = trial - {1'b0, dvs};
    return {trial[WIDTH-1:0], quo[WIDTH-2:0], q_bit};
  endfunction

  assign ready    = (state == IDLE);
  assign acc_push = ready && push_valid;
  assign acc_op   = ready && op_valid && !push_valid;
  assign dm1      = depth - DW'(1);
  assign dm2      = depth - DW'(2);
  assign nos      = mem[dm2[AW-1:0]];
  assign sum      = {1'b0, nos} + {1'b0, top};
  assign diff     = {1'b0, nos} - {1'b0, top};
  assign prod     = {{WIDTH{1'b0}}, nos} * {{WIDTH{1'b0}}, top};
  assign step     = div_step(rem_p1, quo_p1, dvs_p1);

  always_comb begin
    state_nxt     = state;
    depth_nxt     = depth;
    top_nxt       = top;
    ovf_nxt       = ovf;
    err_full_nxt  = err_full;
    err_under_nxt = err_under;
    err_div0_nxt  = err_div0;
    done_nxt      = 1'b0;
    we0           = 1'b0;
    we1           = 1'b0;
    wa0           = '0;
    wa1           = '0;
    wd0           = '0;
    wd1           = '0;
    div_load      = 1'b0;
    if (acc_push || acc_op) begin
      ovf_nxt       = 1'b0;
      err_full_nxt  = 1'b0;
      err_under_nxt = 1'b0;
      err_div0_nxt  = 1'b0;
      done_nxt      = 1'b1;
    end
    if (acc_push) begin
      if (depth < DW'(DEPTH)) begin
        we0       = 1'b1;
        wa0       = depth[AW-1:0];
        wd0       = data_in;
        top_nxt   = data_in;
        depth_nxt = depth + DW'(1);
      end else begin
        err_full_nxt = 1'b1;
      end
    end else if (acc_op) begin
      case (op)
        OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
          if (depth < DW'(2)) begin
            err_under_nxt = 1'b1;
          end else if (op == OP_DIV) begin
            if (top == '0) begin
              err_div0_nxt = 1'b1;
            end else begin
              // Completion is reported from DIV_WB instead.
              div_load  = 1'b1;
              done_nxt  = 1'b0;
              state_nxt = DIV_RUN;
            end
          end else begin
            we0       = 1'b1;
            wa0       = dm2[AW-1:0];
            depth_nxt = dm1;
            case (op)
              OP_ADD:  begin wd0 = sum[WIDTH-1:0];  ovf_nxt = sum[WIDTH];  end
              OP_SUB:  begin wd0 = diff[WIDTH-1:0]; ovf_nxt = diff[WIDTH]; end
              default: begin wd0 = prod[WIDTH-1:0]; ovf_nxt = |prod[2*WIDTH-1:WIDTH]; end
            endcase
            top_nxt = wd0;
          end
        end
        OP_DUP: begin
          if (depth == '0) begin
            err_under_nxt = 1'b1;
          end else if (depth == DW'(DEPTH)) begin
            err_full_nxt = 1'b1;
          end else begin
            we0       = 1'b1;
            wa0       = depth[AW-1:0];
            wd0       = top;
            depth_nxt = depth + DW'(1);
          end
        end
        OP_SWAP: begin
          if (depth < DW'(2)) begin
            err_under_nxt = 1'b1;
          end else begin
            we0     = 1'b1;
            wa0     = dm1[AW-1:0];
            wd0     = nos;
            we1     = 1'b1;
            wa1     = dm2[AW-1:0];
            wd1     = top;
            top_nxt = nos;
          end
        end
        OP_DROP: begin
          if (depth == '0) begin
            err_under_nxt = 1'b1;
          end else begin
            depth_nxt = dm1;
            top_nxt   = (depth >= DW'(2)) ? nos : '0;
          end
        end
        default: begin
          depth_nxt = '0;
          top_nxt   = '0;
        end
      endcase
    end
    case (state)
      DIV_RUN: if (cnt_p1 == '0) state_nxt = DIV_WB;
      DIV_WB: begin
        // Final iteration is folded into the writeback cycle.
        we0       = 1'b1;
        wa0       = dm2[AW-1:0];
        wd0       = step[WIDTH-1:0];
        top_nxt   = step[WIDTH-1:0];
        depth_nxt = dm1;
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      depth     <= '0;
      top       <= '0;
      ovf       <= 1'b0;
      err_full  <= 1'b0;
      err_under <= 1'b0;
      err_div0  <= 1'b0;
      done      <= 1'b0;
      cnt_p1    <= '0;
    end else begin
      state     <= state_nxt;
      depth     <= depth_nxt;
      top       <= top_nxt;
      ovf       <= ovf_nxt;
      err_full  <= err_full_nxt;
      err_under <= err_under_nxt;
      err_div0  <= err_div0_nxt;
      done      <= done_nxt;
      if (div_load) cnt_p1 <= CW'(WIDTH - 2);
      else if (state == DIV_RUN) cnt_p1 <= cnt_p1 - CW'(1);
    end
  end

  // Stack storage and divider working registers (data only, no reset).
  always_ff @(posedge CLOCK_50) begin
    if (we0) mem[wa0] <= wd0;
    if (we1) mem[wa1] <= wd1;
    if (div_load) begin
      dvs_p1 <= top;
      rem_p1 <= '0;
      quo_p1 <= nos;
    end else if (state != IDLE) begin
      rem_p1 <= step[2*WIDTH-1:WIDTH];
      quo_p1 <= step[WIDTH-1:0];
    end
  end

endmodule
